// File: rtl/spi_arbiter.sv
// Two-requester round-robin arbiter in front of a single SPI engine.
// Handles chip-select setup, the start/busy handshake with timeout, and per-requester rx capture.
module spi_arbiter #(
  parameter int CS_SETUP      = 4,
  parameter int START_TIMEOUT = 255
) (
  input  logic        raw_clk,
  input  logic        reset,
  input  logic        req_0,
  input  logic        req_1,
  input  logic        width_16_0,
  input  logic        width_16_1,
  input  logic [15:0] tx_0,
  input  logic [15:0] tx_1,
  output logic [7:0]  rx_0,
  output logic [7:0]  rx_1,
  output logic        done_0,
  output logic        done_1,
  output logic        error_0,
  output logic        error_1,
  output logic        cs_n_0,
  output logic        cs_n_1,
  output logic        spi_start,
  output logic        spi_width_16,
  output logic [15:0] spi_data_tx,
  input  logic        spi_busy,
  input  logic [7:0]  spi_data_rx,
  output logic        busy,
  output logic        owner
);

  localparam int MAXC = (CS_SETUP > START_TIMEOUT) ? CS_SETUP : START_TIMEOUT;
  localparam int CW   = $clog2(MAXC + 2);

  typedef enum logic [2:0] {IDLE, SETUP, START, XFER, DONE} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            owner_q, owner_d;
  logic            last_q, last_d;
  logic [1:0]      cs_n_q, cs_n_d;
  logic [1:0]      done_q, done_d;
  logic [1:0]      err_q, err_d;
  logic            start_q, start_d;
  logic            width_q, width_d;
  logic [15:0]     tx_q, tx_d;
  logic [1:0][7:0] rx_q, rx_d;
  logic [1:0]      req;
  logic            grant;

  assign req = {req_1, req_0};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    last_d  = last_q;
    cs_n_d  = cs_n_q;
    done_d  = '0;
    err_d   = '0;
    start_d = start_q;
    width_d = width_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    grant   = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          // On a tie the requester that was not served last wins.
          grant   = (req == 2'b11) ? ~last_q : req[1];
          owner_d = grant;
          width_d = grant ? width_16_1 : width_16_0;
          tx_d    = grant ? tx_1 : tx_0;
          cs_n_d  = grant ? 2'b01 : 2'b10;
          cnt_d   = '0;
          state_d = (CS_SETUP == 0) ? START : SETUP;
        end
      end
      SETUP: begin
        if (cnt_q == CW'(CS_SETUP - 1)) begin
          cnt_d   = '0;
          state_d = START;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      START: begin
        // First START cycle raises spi_start; the timeout counts cycles with it high.
        if (!start_q) begin
          start_d = 1'b1;
          cnt_d   = '0;
        end else if (spi_busy) begin
          start_d = 1'b0;
          state_d = XFER;
        end else if (cnt_q == CW'(START_TIMEOUT - 1)) begin
          start_d        = 1'b0;
          cs_n_d         = 2'b11;
          err_d[owner_q] = 1'b1;
          last_d         = owner_q;
          state_d        = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      XFER: begin
        if (!spi_busy) begin
          rx_d[owner_q]   = spi_data_rx;
          done_d[owner_q] = 1'b1;
          cs_n_d          = 2'b11;
          state_d         = DONE;
        end
      end
      DONE: begin
        last_d  = owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge raw_clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      cs_n_q  <= 2'b11;
      done_q  <= '0;
      err_q   <= '0;
      start_q <= 1'b0;
      width_q <= 1'b0;
      tx_q    <= '0;
      rx_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cs_n_q  <= cs_n_d;
      done_q  <= done_d;
      err_q   <= err_d;
      start_q <= start_d;
      width_q <= width_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
    end
  end

  assign busy         = (state_q != IDLE);
  assign owner        = owner_q;
  assign cs_n_0       = cs_n_q[0];
  assign cs_n_1       = cs_n_q[1];
  assign done_0       = done_q[0];
  assign done_1       = done_q[1];
  assign error_0      = err_q[0];
  assign error_1      = err_q[1];
  assign spi_start    = start_q;
  assign spi_width_16 = width_q;
  assign spi_data_tx  = tx_q;
  assign rx_0         = rx_q[0];
  assign rx_1         = rx_q[1];

endmodule

// File: tb/tb_spi_arbiter.sv
// Directed and randomized bench for spi_arbiter with a behavioural SPI engine and a
// transaction-level round-robin reference model.
module tb_spi_arbiter;

  logic        raw_clk = 1'b0;
  logic        reset;
  logic        req_0, req_1, width_16_0, width_16_1;
  logic [15:0] tx_0, tx_1;
  logic [7:0]  rx_0, rx_1;
  logic        done_0, done_1, error_0, error_1, cs_n_0, cs_n_1;
  logic        spi_start, spi_width_16, spi_busy, busy, owner;
  logic [15:0] spi_data_tx;
  logic [7:0]  spi_data_rx;

  // second instance with no setup phase and a short timeout; its engine never answers
  logic [7:0]  z0_rx_0, z0_rx_1;
  logic        z0_done_0, z0_done_1, z0_error_0, z0_error_1, z0_cs_n_0, z0_cs_n_1;
  logic        z0_spi_start, z0_spi_width_16, z0_busy, z0_owner;
  logic [15:0] z0_spi_data_tx;
  logic        spi_busy0;
  logic [7:0]  spi_data_rx0;

  int checks = 0, errors = 0;
  int d0n = 0, d1n = 0, e0n = 0, e1n = 0;
  logic       eng_en;
  int         eng_len;
  logic [7:0] eng_rx;

  spi_arbiter dut (
    .raw_clk(raw_clk), .reset(reset),
    .req_0(req_0), .req_1(req_1), .width_16_0(width_16_0), .width_16_1(width_16_1),
    .tx_0(tx_0), .tx_1(tx_1), .rx_0(rx_0), .rx_1(rx_1),
    .done_0(done_0), .done_1(done_1), .error_0(error_0), .error_1(error_1),
    .cs_n_0(cs_n_0), .cs_n_1(cs_n_1), .spi_start(spi_start), .spi_width_16(spi_width_16),
    .spi_data_tx(spi_data_tx), .spi_busy(spi_busy), .spi_data_rx(spi_data_rx),
    .busy(busy), .owner(owner)
  );

  spi_arbiter #(.CS_SETUP(0), .START_TIMEOUT(4)) dut0 (
    .raw_clk(raw_clk), .reset(reset),
    .req_0(req_0), .req_1(req_1), .width_16_0(width_16_0), .width_16_1(width_16_1),
    .tx_0(tx_0), .tx_1(tx_1), .rx_0(z0_rx_0), .rx_1(z0_rx_1),
    .done_0(z0_done_0), .done_1(z0_done_1), .error_0(z0_error_0), .error_1(z0_error_1),
    .cs_n_0(z0_cs_n_0), .cs_n_1(z0_cs_n_1), .spi_start(z0_spi_start),
    .spi_width_16(z0_spi_width_16), .spi_data_tx(z0_spi_data_tx), .spi_busy(spi_busy0),
    .spi_data_rx(spi_data_rx0), .busy(z0_busy), .owner(z0_owner)
  );

  always #5 raw_clk = ~raw_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge raw_clk);
    #1;
  endtask

  // Engine: answers spi_start by raising busy for eng_len cycles, then presents eng_rx.
  initial begin
    spi_busy    = 1'b0;
    spi_data_rx = 8'h00;
    forever begin
      @(posedge raw_clk);
      #1;
      if (eng_en && spi_start && !spi_busy) begin
        spi_busy = 1'b1;
        repeat (eng_len) @(posedge raw_clk);
        #1;
        spi_data_rx = eng_rx;
        spi_busy    = 1'b0;
      end
    end
  end

  // Pulse counters and chip-select exclusivity/ownership, sampled mid-cycle.
  always @(negedge raw_clk) begin
    if (done_0)  d0n++;
    if (done_1)  d1n++;
    if (error_0) e0n++;
    if (error_1) e1n++;
    if (!reset) begin
      chk("cs_excl", (cs_n_0 || cs_n_1) && (cs_n_0 || (busy && !owner)) &&
                     (cs_n_1 || (busy && owner)), 1);
      chk("cs_excl_z0", (z0_cs_n_0 || z0_cs_n_1) && (z0_cs_n_0 || (z0_busy && !z0_owner)) &&
                        (z0_cs_n_1 || (z0_busy && z0_owner)), 1);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, lat0, hi, ds, es, d1s, e1s;
    logic       last_m, exp_own, exp_w;
    logic [15:0] exp_tx;
    logic [7:0] rx_m [2];
    logic [7:0] rx1_prev;

    reset = 1'b1; req_0 = 1'b0; req_1 = 1'b0; width_16_0 = 1'b0; width_16_1 = 1'b0;
    tx_0 = '0; tx_1 = '0; eng_en = 1'b1; eng_len = 8; eng_rx = 8'h3C;
    spi_busy0 = 1'b0; spi_data_rx0 = 8'h5A;
    repeat (3) tick();

    // reset values
    chk("rst_busy", busy, 0);
    chk("rst_cs_n", {cs_n_1, cs_n_0}, 2'b11);
    chk("rst_start", spi_start, 0);
    chk("rst_tx", spi_data_tx, 0);
    chk("rst_w", spi_width_16, 0);
    chk("rst_rx", {rx_1, rx_0}, 0);
    chk("rst_owner", owner, 0);
    chk("rst_pulses", {done_1, done_0, error_1, error_0}, 0);
    chk("rst_z0", {z0_cs_n_1, z0_cs_n_0, z0_busy, z0_owner, z0_done_1, z0_error_1, z0_rx_1}, 6'b110000 << 8);
    reset = 1'b0;
    tick();

    // single 8-bit transfer from requester 0; setup latency on both instances
    req_0 = 1'b1; tx_0 = 16'h00A5; width_16_0 = 1'b0;
    for (int i = 0; i < 20 && cs_n_0; i++) tick();
    chk("t1_grant", cs_n_0, 0);
    chk("t1_tx", spi_data_tx, 16'h00A5);
    chk("t1_w", spi_width_16, 0);
    chk("t1_owner", {busy, owner}, 2'b10);
    chk("t1_z0_grant", {z0_cs_n_0, z0_spi_width_16}, 0);
    chk("t1_z0_tx", z0_spi_data_tx, 16'h00A5);
    lat = -1; lat0 = -1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (lat < 0 && spi_start) lat = k;
      if (lat0 < 0 && z0_spi_start) lat0 = k;
      if (k == 5) chk("t1_z0_timeout", {z0_error_0, z0_done_0, z0_cs_n_0, z0_rx_0}, 11'b101 << 8);
    end
    chk("t1_start_lat", lat, 5);
    chk("t1_z0_start_lat", lat0, 1);
    req_0 = 1'b0;
    for (int i = 0; i < 40 && !done_0; i++) tick();
    chk("t1_done", done_0, 1);
    chk("t1_rx", rx_0, 8'h3C);
    chk("t1_cs_off", cs_n_0, 1);
    repeat (5) tick();
    chk("t1_done_cnt", d0n, 1);
    chk("t1_idle", {busy, cs_n_0}, 2'b01);

    // both requesting after reset: grant order 0,1,0,1 with one idle gap between
    reset = 1'b1; tick(); reset = 1'b0; tick();
    req_0 = 1'b1; req_1 = 1'b1; eng_len = 3;
    exp_own = 1'b0;
    for (int t = 0; t < 4; t++) begin
      eng_rx = 8'h10 + 8'(t);
      for (int i = 0; i < 10 && !busy; i++) tick();
      chk("rr_owner", {busy, owner}, {1'b1, exp_own});
      for (int i = 0; i < 40 && !(done_0 || done_1); i++) tick();
      chk("rr_done", {done_1, done_0}, exp_own ? 2'b10 : 2'b01);
      if (t == 3) begin req_0 = 1'b0; req_1 = 1'b0; end
      tick();
      chk("rr_gap", {busy, cs_n_1, cs_n_0}, 3'b011);
      exp_own = ~exp_own;
    end

    // engine never answers: 255-cycle start window, then error_1
    eng_en = 1'b0; rx1_prev = rx_1; d1s = d1n; e1s = e1n;
    req_1 = 1'b1;
    for (int i = 0; i < 10 && cs_n_1; i++) tick();
    req_1 = 1'b0;
    for (int i = 0; i < 20 && !spi_start; i++) tick();
    chk("to_start", spi_start, 1);
    hi = 0;
    while (spi_start && hi < 400) begin tick(); hi++; end
    chk("to_len", hi, 255);
    chk("to_err", {error_1, busy, cs_n_1}, 3'b101);
    chk("to_rx", rx_1, rx1_prev);
    repeat (3) tick();
    chk("to_err_cnt", e1n, e1s + 1);
    chk("to_no_done", d1n, d1s);
    eng_en = 1'b1;

    // reset in XFER: everything drops at once, no pulses
    eng_len = 8; req_0 = 1'b1;
    for (int i = 0; i < 40 && !(busy && spi_busy && !spi_start); i++) tick();
    chk("rx_xfer", {busy, spi_busy, spi_start}, 3'b110);
    req_0 = 1'b0;
    tick();
    ds = d0n + d1n; es = e0n + e1n;
    reset = 1'b1;
    #2;
    chk("rx_async", {busy, spi_start, cs_n_1, cs_n_0}, 4'b0011);
    tick(); tick();
    reset = 1'b0;
    for (int i = 0; i < 20 && spi_busy; i++) tick();
    tick();
    chk("rx_no_pulse", {d0n + d1n, e0n + e1n}, {ds, es});
    chk("rx_idle", busy, 0);

    // req/tx/width changes during SETUP are ignored
    eng_len = 4; eng_rx = 8'hC7;
    req_1 = 1'b1; tx_1 = 16'h1234; width_16_1 = 1'b1;
    for (int i = 0; i < 10 && cs_n_1; i++) tick();
    chk("mid_grant", {busy, owner, cs_n_1}, 3'b110);
    tx_1 = 16'hFFFF; req_1 = 1'b0; width_16_1 = 1'b0;
    tick(); tick();
    chk("mid_tx", spi_data_tx, 16'h1234);
    chk("mid_w", spi_width_16, 1);
    for (int i = 0; i < 50 && !done_1; i++) tick();
    chk("mid_done", done_1, 1);
    chk("mid_rx", rx_1, 8'hC7);

    // randomized transactions against a round-robin reference
    for (int i = 0; i < 10 && busy; i++) tick();
    reset = 1'b1; tick(); reset = 1'b0; tick();
    last_m = 1'b1; rx_m[0] = 8'h00; rx_m[1] = 8'h00;
    for (int n = 0; n < 12; n++) begin
      int r;
      r = int'($urandom_range(1, 3));
      req_0 = r[0]; req_1 = r[1];
      tx_0 = 16'($urandom); tx_1 = 16'($urandom);
      width_16_0 = 1'($urandom_range(0, 1)); width_16_1 = 1'($urandom_range(0, 1));
      eng_rx = 8'($urandom); eng_len = int'($urandom_range(1, 5));
      exp_own = (r == 3) ? ~last_m : (r == 2);
      exp_tx  = exp_own ? tx_1 : tx_0;
      exp_w   = exp_own ? width_16_1 : width_16_0;
      for (int i = 0; i < 10 && busy; i++) tick();
      for (int i = 0; i < 10 && !busy; i++) tick();
      chk("rnd_owner", {busy, owner}, {1'b1, exp_own});
      chk("rnd_tx", spi_data_tx, exp_tx);
      chk("rnd_w", spi_width_16, exp_w);
      if ($urandom_range(0, 1) == 1) begin
        req_0 = 1'($urandom_range(0, 1)); req_1 = 1'($urandom_range(0, 1));
        tx_0 = 16'($urandom); tx_1 = 16'($urandom);
      end
      for (int i = 0; i < 300 && !(done_0 || done_1); i++) tick();
      chk("rnd_done", {done_1, done_0}, exp_own ? 2'b10 : 2'b01);
      rx_m[exp_own] = eng_rx;
      last_m = exp_own;
      chk("rnd_rx0", rx_0, rx_m[0]);
      chk("rnd_rx1", rx_1, rx_m[1]);
    end
    req_0 = 1'b0; req_1 = 1'b0;
    repeat (4) tick();
    chk("end_idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
